// File: rtl/band_bar_driver_pkg.sv
// band_bar_driver_pkg
// Shared definitions for the band bar display driver:
//   - default configuration values for the driver and its bus interface
//   - TOTAL_BITS / LED_STEP for the default configuration
//   - FSM state encoding
//   - thermometer encoder that turns a held peak into a lit-LED bar
package band_bar_driver_pkg;

    localparam int DEF_NUM_BANDS   = 4;
    localparam int DEF_ENERGY_BITS = 8;
    localparam int DEF_BAR_LEDS    = 8;
    localparam int DEF_HOLD_FRAMES = 8;
    localparam int DEF_DECAY_STEP  = 4;
    localparam int DEF_SCLK_DIV    = 4;

    // Bits shifted per frame and energy span covered by one LED.
    localparam int TOTAL_BITS = DEF_NUM_BANDS * DEF_BAR_LEDS;
    localparam int LED_STEP   = (1 << DEF_ENERGY_BITS) / DEF_BAR_LEDS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } bar_state_e;

    // LED k is lit iff peak > k*step. The loop bound is fixed at 32 so the
    // function stays static; bits at or above 'leds' are always zero.
    function automatic logic [31:0] therm_encode(input logic [31:0] peak,
                                                 input int          leds,
                                                 input int          step);
        logic [31:0] code;
        code = '0;
        for (int k = 0; k < 32; k++) begin
            if ((k < leds) && (peak > 32'(k * step))) begin
                code[k] = 1'b1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/band_bar_driver_if.sv
// band_bar_driver_if
// Bundles the frame input and the display/status outputs of band_bar_driver.
//   master : frame source side (drives frame_valid, band_energy)
//   slave  : driver side (drives serial chain, status and debug outputs)
// Signals:
//   frame_valid  one-cycle strobe, band_energy valid in that cycle
//   band_energy  NUM_BANDS x ENERGY_BITS, band 0 in the LSBs
//   ser_data / ser_clk / ser_latch  to the 74HC595-style chain
//   busy         frame being processed or shifted
//   overrun      sticky, a frame arrived while busy
//   peak_level   current held peaks, band 0 in the LSBs
interface band_bar_driver_if
    import band_bar_driver_pkg::*;
#(
    parameter int NUM_BANDS   = DEF_NUM_BANDS,
    parameter int ENERGY_BITS = DEF_ENERGY_BITS
);
    logic                               frame_valid;
    logic [NUM_BANDS*ENERGY_BITS-1:0]   band_energy;
    logic                               ser_data;
    logic                               ser_clk;
    logic                               ser_latch;
    logic                               busy;
    logic                               overrun;
    logic [NUM_BANDS*ENERGY_BITS-1:0]   peak_level;

    modport master (
        output frame_valid, band_energy,
        input  ser_data, ser_clk, ser_latch, busy, overrun, peak_level
    );

    modport slave (
        input  frame_valid, band_energy,
        output ser_data, ser_clk, ser_latch, busy, overrun, peak_level
    );

endinterface

// File: rtl/band_bar_driver_peak_hold_cell.sv
// peak_hold_cell
// Peak-hold with linear decay for one band. On each accept strobe:
//   energy >= peak       : take the new peak and restart the hold counter
//   hold counter running : count it down, keep the peak
//   hold expired         : peak = max(energy, peak - DECAY_STEP clamped at 0)
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   accept    one-cycle update strobe
//   energy    this band's energy for the accepted frame
//   peak      registered held peak
module peak_hold_cell #(
    parameter int ENERGY_BITS = 8,
    parameter int HOLD_FRAMES = 8,
    parameter int DECAY_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept,
    input  logic [ENERGY_BITS-1:0] energy,
    output logic [ENERGY_BITS-1:0] peak
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [HOLD_W-1:0]      hold;
    logic [ENERGY_BITS-1:0] decayed;

    // peak - DECAY_STEP, clamped at zero instead of wrapping.
    function automatic logic [ENERGY_BITS-1:0] sat0_decay(input logic [ENERGY_BITS-1:0] p);
        logic signed [32:0] diff;
        diff = $signed({1'b0, 32'(p)}) - $signed(33'(DECAY_STEP));
        if (diff < 0) begin
            return '0;
        end
        return ENERGY_BITS'(diff);
    endfunction

    assign decayed = sat0_decay(peak);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak <= '0;
            hold <= '0;
        end else if (accept) begin
            if (energy >= peak) begin
                peak <= energy;
                hold <= HOLD_W'(HOLD_FRAMES);
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end else begin
                peak <= (energy > decayed) ? energy : decayed;
            end
        end
    end

endmodule

// File: rtl/band_bar_driver.sv
// band_bar_driver
// Display stage of the spectrum analyzer: keeps a peak-hold/decay value per
// band, converts each peak to a thermometer bar and shifts all bars MSB first
// (band NUM_BANDS-1, LED BAR_LEDS-1 first) into an external 74HC595-style
// chain, followed by one latch pulse.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  band_bar_driver_if.slave: frame_valid/band_energy in;
//        ser_data/ser_clk/ser_latch/busy/overrun/peak_level out (all registered)
module band_bar_driver
    import band_bar_driver_pkg::*;
#(
    parameter int NUM_BANDS   = DEF_NUM_BANDS,
    parameter int ENERGY_BITS = DEF_ENERGY_BITS,
    parameter int BAR_LEDS    = DEF_BAR_LEDS,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int DECAY_STEP  = DEF_DECAY_STEP,
    parameter int SCLK_DIV    = DEF_SCLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    band_bar_driver_if.slave  bus
);

    localparam int TOT_BITS = NUM_BANDS * BAR_LEDS;
    localparam int STEP     = (1 << ENERGY_BITS) / BAR_LEDS;
    localparam int CNT_W    = (TOT_BITS > 1) ? $clog2(TOT_BITS) : 1;
    localparam int DIV_W    = $clog2(SCLK_DIV + 1);

    bar_state_e             state, state_nxt;
    logic [DIV_W-1:0]       div_cnt, div_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_nxt;
    logic [TOT_BITS-1:0]    shreg, shreg_nxt;
    logic [TOT_BITS-1:0]    therm_all;
    logic                   accept;
    logic                   div_last;
    logic                   bit_last;

    logic                   ser_data_q;
    logic                   ser_clk_q;
    logic                   ser_latch_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic [ENERGY_BITS-1:0] peaks [NUM_BANDS];

    // ---- per-band peak hold ----
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        peak_hold_cell #(
            .ENERGY_BITS (ENERGY_BITS),
            .HOLD_FRAMES (HOLD_FRAMES),
            .DECAY_STEP  (DECAY_STEP)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .accept (accept),
            .energy (bus.band_energy[b*ENERGY_BITS +: ENERGY_BITS]),
            .peak   (peaks[b])
        );
        assign bus.peak_level[b*ENERGY_BITS +: ENERGY_BITS] = peaks[b];
    end

    // Bars laid out so band NUM_BANDS-1 / LED BAR_LEDS-1 sits at the MSB.
    always_comb begin
        therm_all = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            therm_all[b*BAR_LEDS +: BAR_LEDS] =
                BAR_LEDS'(therm_encode(32'(peaks[b]), BAR_LEDS, STEP));
        end
    end

    assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign bit_last = (bit_cnt == CNT_W'(TOT_BITS - 1));

    // ---- sequencer: next state ----
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.frame_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                shreg_nxt = therm_all;
                bit_nxt   = '0;
                div_nxt   = '0;
                state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_nxt   = '0;
                    state_nxt = SHIFT_HI;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_nxt   = '0;
                    shreg_nxt = shreg << 1;
                    bit_nxt   = bit_cnt + 1'b1;
                    state_nxt = bit_last ? LATCH : SHIFT_LO;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- sequencer / output registers ----
    // Outputs are decoded from the next state so they line up with the state
    // they belong to. ser_data only reloads on entry to SHIFT_LO, so it never
    // moves while ser_clk is high or during the latch pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            bit_cnt     <= bit_nxt;
            ser_clk_q   <= (state_nxt == SHIFT_HI);
            ser_latch_q <= (state_nxt == LATCH);
            busy_q      <= (state_nxt != IDLE);
            if (state_nxt == SHIFT_LO) begin
                ser_data_q <= shreg_nxt[TOT_BITS-1];
            end
            if (bus.frame_valid && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Shift register is pure data: reloaded in LOAD before it is ever used.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    assign bus.ser_data  = ser_data_q;
    assign bus.ser_clk   = ser_clk_q;
    assign bus.ser_latch = ser_latch_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_band_bar_driver.sv
// tb_band_bar_driver
// Scoreboard bench for band_bar_driver (default parameters). Stimulus pushes
// the hand-computed shifted word and peak vector for each accepted frame; an
// independent monitor rebuilds the word from ser_clk rising edges and checks
// it, the latch width and the busy length whenever a latch pulse appears.
module tb_band_bar_driver;
    import band_bar_driver_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] peaks;
    } exp_t;

    localparam int BUSY_LEN = 1 + 2 * DEF_SCLK_DIV * TOTAL_BITS + DEF_SCLK_DIV;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];

    band_bar_driver_if bus ();

    band_bar_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_sclk;
        logic        prev_latch;
        logic        prev_busy;
        logic [31:0] sh;
        int          nbits;
        int          lat_w;
        int          busy_w;
        exp_t        e;
        prev_sclk  = 1'b0;
        prev_latch = 1'b0;
        prev_busy  = 1'b0;
        sh         = '0;
        nbits      = 0;
        lat_w      = 0;
        busy_w     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sclk  = 1'b0;
                prev_latch = 1'b0;
                prev_busy  = 1'b0;
                sh         = '0;
                nbits      = 0;
                lat_w      = 0;
                busy_w     = 0;
            end else begin
                if (bus.ser_clk && !prev_sclk) begin
                    sh = {sh[30:0], bus.ser_data};
                    nbits++;
                end
                if (bus.busy) busy_w++;
                if (bus.ser_latch) lat_w++;
                if (bus.ser_latch && !prev_latch) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_latch: got latch pulse, required none");
                    end else begin
                        e = sb_q.pop_front();
                        chk("shift_word", sh, e.word);
                        chk("shift_bits", 32'(nbits), 32'(TOTAL_BITS));
                        chk("peak_level", bus.peak_level, e.peaks);
                    end
                    sh    = '0;
                    nbits = 0;
                end
                if (!bus.ser_latch && prev_latch) begin
                    chk("latch_width", 32'(lat_w), 32'(DEF_SCLK_DIV));
                    lat_w = 0;
                end
                if (!bus.busy && prev_busy) begin
                    chk("busy_length", 32'(busy_w), 32'(BUSY_LEN));
                    busy_w = 0;
                end
                prev_sclk  = bus.ser_clk;
                prev_latch = bus.ser_latch;
                prev_busy  = bus.busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] e);
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.band_energy = e;
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles, required idle", tag, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] e, input logic [31:0] word, input logic [31:0] peaks);
        sb_q.push_back('{word: word, peaks: peaks});
        send_frame(e);
        wait_idle("frame_done");
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic sclk_seen;
        logic latch_seen;
        int   edges;
        int   n;
        logic prev;

        n_cmp           = 0;
        n_fail          = 0;
        rst             = 1'b0;
        bus.frame_valid = 1'b0;
        bus.band_energy = '0;

        // 1. reset
        do_reset();
        chk("rst_ser_data",   32'(bus.ser_data),  32'd0);
        chk("rst_ser_clk",    32'(bus.ser_clk),   32'd0);
        chk("rst_ser_latch",  32'(bus.ser_latch), 32'd0);
        chk("rst_busy",       32'(bus.busy),      32'd0);
        chk("rst_overrun",    32'(bus.overrun),   32'd0);
        chk("rst_peak_level", bus.peak_level,     32'd0);
        sclk_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            sclk_seen |= bus.ser_clk;
        end
        chk("idle_no_sclk", 32'(sclk_seen), 32'd0);

        // 2. single frame: bands 0..3 = 255, 33, 32, 0
        sb_q.push_back('{word: 32'h0001_03FF, peaks: 32'h0020_21FF});
        send_frame(32'h0020_21FF);
        chk("busy_rise",    32'(bus.busy),  32'd1);
        chk("peak_visible", bus.peak_level, 32'h0020_21FF);
        wait_idle("single");

        // 3. hold then decay: 200 held for 8 frames, then 196, 192
        do_reset();
        run_frame(32'hC8C8_C8C8, 32'h7F7F_7F7F, 32'hC8C8_C8C8);
        for (int i = 0; i < 8; i++) begin
            run_frame(32'h0, 32'h7F7F_7F7F, 32'hC8C8_C8C8);
        end
        run_frame(32'h0, 32'h7F7F_7F7F, 32'hC4C4_C4C4);
        run_frame(32'h0, 32'h3F3F_3F3F, 32'hC0C0_C0C0);

        // 4. decay floors: band0 2 -> 0 (no wrap), band1 100 -> 98
        do_reset();
        run_frame(32'h0000_6402, 32'h0000_0F01, 32'h0000_6402);
        for (int i = 0; i < 8; i++) begin
            run_frame(32'h0, 32'h0000_0F01, 32'h0000_6402);
        end
        run_frame(32'h0000_6200, 32'h0000_0F00, 32'h0000_6200);

        // 5. overrun: frame mid-shift is dropped, overrun sticks
        do_reset();
        sb_q.push_back('{word: 32'h0001_03FF, peaks: 32'h0020_21FF});
        send_frame(32'h0020_21FF);
        repeat (97) @(negedge clk);
        send_frame(32'hFFFF_FFFF);
        chk("overrun_set",    32'(bus.overrun), 32'd1);
        chk("overrun_peaks",  bus.peak_level,   32'h0020_21FF);
        wait_idle("overrun");
        run_frame(32'h4000_0000, 32'h0301_03FF, 32'h4020_21FF);
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        // 6. reset after bit 10 of a shift: no latch, next frame complete
        do_reset();
        chk("rst_clears_overrun", 32'(bus.overrun), 32'd0);
        send_frame(32'h0020_21FF);
        edges = 0;
        n     = 0;
        prev  = 1'b0;
        while (edges < 11 && n < 1000) begin
            @(negedge clk);
            if (bus.ser_clk && !prev) edges++;
            prev = bus.ser_clk;
            n++;
        end
        chk("bits_before_rst", 32'(edges), 32'd11);
        rst = 1'b1;
        #1;
        chk("midrst_outputs",
            {27'd0, bus.ser_data, bus.ser_clk, bus.ser_latch, bus.busy, bus.overrun}, 32'd0);
        chk("midrst_peaks", bus.peak_level, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        latch_seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            latch_seen |= bus.ser_latch;
        end
        chk("midrst_no_latch", 32'(latch_seen), 32'd0);
        run_frame(32'hFF00_6401, 32'hFF00_0F01, 32'hFF00_6401);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
